// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-requester (CPU / debug) arbiter for the single-ported data
//            memory. Accesses go through a three-state sequencer
//            (IDLE -> ACCESS -> RESP), and the CPU is stalled while its
//            access is pending.
// Options  : DMEM_ARB_RR_EN - round-robin on contention; debug always wins
//            if the macro is undefined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module dmem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                owner_q, owner_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic                dbg_prio;
  logic                grant_dbg;

`ifdef DMEM_ARB_RR_EN
  // 1 = debug is favoured on the next contended grant
  logic rr_q, rr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= 1'b1;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign dbg_prio = rr_q;
`else
  assign dbg_prio = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    owner_d     = owner_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    cpu_ack     = 1'b0;
    dbg_ack     = 1'b0;
    grant_dbg   = dbg_req & (~cpu_req | dbg_prio);
`ifdef DMEM_ARB_RR_EN
    rr_d        = rr_q;
`endif

    case (state_q)
      IDLE: begin
        if (cpu_req | dbg_req) begin
          owner_d = grant_dbg;
          we_d    = grant_dbg ? dbg_we    : cpu_we;
          addr_d  = grant_dbg ? dbg_addr  : cpu_addr;
          wdata_d = grant_dbg ? dbg_wdata : cpu_wdata;
          state_d = ACCESS;
`ifdef DMEM_ARB_RR_EN
          rr_d    = ~grant_dbg;
`endif
        end
      end
      ACCESS: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_read  = ~we_q;
        mem_write = we_q;
        // Only the owner's read register ever changes.
        if (!we_q) begin
          if (owner_q) begin
            dbg_rdata_d = mem_rdata;
          end else begin
            cpu_rdata_d = mem_rdata;
          end
        end
        state_d = RESP;
      end
      RESP: begin
        cpu_ack = ~owner_q;
        dbg_ack = owner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      owner_q     <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      owner_q     <= owner_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign owner     = owner_q;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed testbench for dmem_arbiter using a vector table plus
//            hand-written multi-cycle sequences (reset, contention, drop).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we, dbg_req, dbg_we;
  logic [ADDR_W-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DATA_W-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              cpu_ack, cpu_stall, dbg_ack, mem_read, mem_write, owner;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  // Word-addressed data memory: combinational read, write on the rising edge.
  logic [DATA_W-1:0] mem [0:2047];
  assign mem_rdata = mem_read ? mem[mem_addr[12:2]] : '0;
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[12:2]] <= mem_wdata;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  typedef struct packed {
    logic        is_dbg;
    logic        we;
    logic [12:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_crd;
    logic [31:0] exp_drd;
  } vec_t;

  function automatic vec_t mk(input logic d, input logic w, input logic [12:0] a,
                              input logic [31:0] wd, input logic [31:0] c, input logic [31:0] r);
    vec_t v;
    v.is_dbg = d; v.we = w; v.addr = a; v.wd = wd; v.exp_crd = c; v.exp_drd = r;
    return v;
  endfunction

  task automatic drive_vec(input vec_t v);
    idle_inputs();
    if (v.is_dbg) begin
      dbg_req = 1'b1; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wd;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wd;
    end
  endtask

  // Inputs already driven; the request is sampled at the next rising edge.
  task automatic check_txn(input vec_t v, input string tag);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk({tag, "_mem_rd"},   {31'd0, mem_read},  {31'd0, ~v.we});
        chk({tag, "_mem_wr"},   {31'd0, mem_write}, {31'd0, v.we});
        chk({tag, "_mem_addr"}, {19'd0, mem_addr},  {19'd0, v.addr});
        chk({tag, "_mem_wd"},   mem_wdata,          v.we ? v.wd : 32'd0);
      end else begin
        chk($sformatf("%s_c%0d_mem_idle", tag, c),
            {30'd0, mem_read, mem_write}, 32'd0);
        chk($sformatf("%s_c%0d_addr_idle", tag, c), {19'd0, mem_addr}, 32'd0);
      end
      if (c == 2) begin
        chk({tag, "_acks"},  {30'd0, cpu_ack, dbg_ack}, {30'd0, ~v.is_dbg, v.is_dbg});
        chk({tag, "_owner"}, {31'd0, owner},     {31'd0, v.is_dbg});
        chk({tag, "_crd"},   cpu_rdata,          v.exp_crd);
        chk({tag, "_drd"},   dbg_rdata,          v.exp_drd);
      end else begin
        chk($sformatf("%s_c%0d_noack", tag, c), {30'd0, cpu_ack, dbg_ack}, 32'd0);
      end
      chk($sformatf("%s_c%0d_stall", tag, c), {31'd0, cpu_stall},
          {31'd0, ~v.is_dbg & (c < 2)});
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  vec_t vecs [0:10];

  initial begin
    vecs[0]  = mk(1'b0, 1'b1, 13'h010,  32'hDEADBEEF, 32'h00000000, 32'h00000000);
    vecs[1]  = mk(1'b0, 1'b0, 13'h010,  32'h0,        32'hDEADBEEF, 32'h00000000);
    vecs[2]  = mk(1'b1, 1'b1, 13'h1FFC, 32'h12345678, 32'hDEADBEEF, 32'h00000000);
    vecs[3]  = mk(1'b0, 1'b0, 13'h1FFC, 32'h0,        32'h12345678, 32'h00000000);
    vecs[4]  = mk(1'b1, 1'b0, 13'h010,  32'h0,        32'h12345678, 32'hDEADBEEF);
    vecs[5]  = mk(1'b1, 1'b1, 13'h004,  32'hA5A50F0F, 32'h12345678, 32'hDEADBEEF);
    vecs[6]  = mk(1'b0, 1'b1, 13'h008,  32'h00001111, 32'h12345678, 32'hDEADBEEF);
    vecs[7]  = mk(1'b1, 1'b0, 13'h008,  32'h0,        32'h12345678, 32'h00001111);
    vecs[8]  = mk(1'b0, 1'b0, 13'h004,  32'h0,        32'hA5A50F0F, 32'h00001111);
    vecs[9]  = mk(1'b0, 1'b0, 13'h020,  32'h0,        32'h0BADF00D, 32'h00001111);
    vecs[10] = mk(1'b1, 1'b0, 13'h1FFC, 32'h0,        32'h0BADF00D, 32'h12345678);

    // Reset held with a pending CPU write; nothing may reach memory.
    reset = 1'b1;
    drive_vec(mk(1'b0, 1'b1, 13'h020, 32'h0BADF00D, 32'h0, 32'h0));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst_c%0d_mem", c), {30'd0, mem_read, mem_write}, 32'd0);
      chk($sformatf("rst_c%0d_ack", c), {29'd0, cpu_ack, dbg_ack, owner}, 32'd0);
    end
    chk("rst_mem_addr", {19'd0, mem_addr}, 32'd0);
    chk("rst_mem_wd",   mem_wdata, 32'd0);
    chk("rst_crd",      cpu_rdata, 32'd0);
    chk("rst_drd",      dbg_rdata, 32'd0);
    chk("rst_stall",    {31'd0, cpu_stall}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    check_txn(mk(1'b0, 1'b1, 13'h020, 32'h0BADF00D, 32'h0, 32'h0), "rst_rel");

    // Single-requester transaction table.
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      drive_vec(vecs[i]);
      check_txn(vecs[i], $sformatf("v%0d", i));
    end

    // Reset during RESP of a CPU read.
    @(posedge clk); #1;
    drive_vec(mk(1'b0, 1'b0, 13'h010, 32'h0, 32'h0, 32'h0));
    repeat (3) @(negedge clk);
    chk("rresp_ack",  {31'd0, cpu_ack}, 32'd1);
    chk("rresp_crd0", cpu_rdata, 32'hDEADBEEF);
    reset = 1'b1;
    @(negedge clk);
    chk("rresp_ack_low", {30'd0, cpu_ack, dbg_ack}, 32'd0);
    chk("rresp_crd",     cpu_rdata, 32'd0);
    chk("rresp_drd",     dbg_rdata, 32'd0);
    chk("rresp_owner",   {31'd0, owner}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("rresp_idle", {28'd0, mem_read, mem_write, cpu_ack, dbg_ack}, 32'd0);

    // CPU drops its request during ACCESS: ack once, then nothing further.
    @(posedge clk); #1;
    drive_vec(mk(1'b0, 1'b0, 13'h004, 32'h0, 32'h0, 32'h0));
    @(negedge clk);
    @(negedge clk);
    chk("drop_access", {31'd0, mem_read}, 32'd1);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("drop_ack", {30'd0, cpu_ack, dbg_ack}, 32'd2);
    chk("drop_crd", cpu_rdata, 32'hA5A50F0F);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("drop_quiet%0d", c), {28'd0, mem_read, mem_write, cpu_ack, dbg_ack}, 32'd0);
    end

    // Contention, both held: debug read 0x004, CPU read 0x008.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 13'h004;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h008;
    for (int c = 0; c < 12; c++) begin
      logic exp_c, exp_d;
      @(negedge clk);
      exp_c = 1'b0;
      exp_d = 1'b0;
      if (c % 3 == 2) begin
`ifdef DMEM_ARB_RR_EN
        exp_d = ((c / 3) % 2 == 0);
        exp_c = ~exp_d;
`else
        exp_d = 1'b1;
`endif
      end
      chk($sformatf("cont_c%0d_acks", c), {30'd0, cpu_ack, dbg_ack}, {30'd0, exp_c, exp_d});
      chk($sformatf("cont_c%0d_stall", c), {31'd0, cpu_stall}, {31'd0, ~exp_c});
      if (exp_d) chk($sformatf("cont_c%0d_drd", c), dbg_rdata, 32'hA5A50F0F);
      if (exp_c) chk($sformatf("cont_c%0d_crd", c), cpu_rdata, 32'h00001111);
    end
`ifndef DMEM_ARB_RR_EN
    chk("cont_crd_untouched", cpu_rdata, 32'd0);
`endif
    @(posedge clk); #1;
    idle_inputs();

    // Debug write to 0x1FFC while the CPU is stalled reading the same word.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 13'h1FFC; dbg_wdata = 32'hCAFEF00D;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1FFC;
    repeat (3) @(negedge clk);
    chk("dws_dbg_ack", {30'd0, cpu_ack, dbg_ack}, 32'd1);
    chk("dws_stall",   {31'd0, cpu_stall}, 32'd1);
    chk("dws_owner",   {31'd0, owner}, 32'd1);
    chk("dws_drd",     dbg_rdata, 32'd0);
    dbg_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("dws_cpu_access", {19'd0, mem_addr}, 32'h1FFC);
    @(negedge clk);
    chk("dws_cpu_ack", {30'd0, cpu_ack, dbg_ack}, 32'd2);
    chk("dws_crd",     cpu_rdata, 32'hCAFEF00D);
    chk("dws_drd2",    dbg_rdata, 32'd0);
    chk("dws_owner2",  {31'd0, owner}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
